// File: rtl/uart_alu_if.sv
// uart_alu_if: collects A, B and opcode bytes from a UART RX FIFO, latches the ALU result and pushes it to the TX FIFO
module uart_alu_if #(
   parameter int DBIT = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx_empty,
   input  logic [DBIT-1:0] r_data,
   output logic            rd_uart,
   input  logic            tx_full,
   output logic            wr_uart,
   output logic [DBIT-1:0] w_data,
   output logic [DBIT-1:0] a,
   output logic [DBIT-1:0] b,
   output logic [DBIT-1:0] op,
   input  logic [DBIT-1:0] w,
   output logic [DBIT-1:0] led
);
   typedef enum logic [2:0] {IDLE_A, GET_B, GET_OP, EXEC, SEND} state_t;
   state_t state, state_n;
   logic rd_q;
   logic [DBIT-1:0] res;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE_A;
         rd_q  <= 1'b0;
      end else begin
         state <= state_n;
         rd_q  <= rd_uart;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         a   <= '0;
         b   <= '0;
         op  <= '0;
         res <= '0;
         led <= '0;
      end else begin
         if (rd_uart && state == IDLE_A) a <= r_data;
         if (rd_uart && state == GET_B) b <= r_data;
         if (rd_uart && state == GET_OP) op <= r_data;
         if (state == EXEC) res <= w;
         if (wr_uart) led <= res;
      end
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE_A:  state_n = rd_uart ? GET_B : IDLE_A;
         GET_B:   state_n = rd_uart ? GET_OP : GET_B;
         GET_OP:  state_n = rd_uart ? EXEC : GET_OP;
         EXEC:    state_n = SEND;
         SEND:    state_n = wr_uart ? IDLE_A : SEND;
         default: state_n = IDLE_A;
      endcase
   end
   // rd_q spaces pops so the FIFO head has a full cycle to advance
   always_comb begin
      rd_uart = !reset && !rd_q && !rx_empty && (state == IDLE_A || state == GET_B || state == GET_OP);
      wr_uart = !reset && !tx_full && state == SEND;
   end
   assign w_data = res;
endmodule
